// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared definitions for the multi-read-port register file.
//   - state_t     : clear/ready state encoding of the register file controller
//   - slice_lsb() : LSB position of element idx in a flat vector of width-bit elements
package regfile_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Data slice of port/entry idx lives at [slice_lsb(idx, width) +: width].
  function automatic int unsigned slice_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port
//   One registered read port of register_file_mp: address mux over the flat
//   storage vector, zero-register gate, optional write-first bypass and the
//   output data register.
//   Optional feature: REGFILE_BYPASS_EN adds the wr_en/wr_addr/wr_data ports
//   and the per-port write/read address comparator.
// Ports
//   clk       in   1              clock, rising edge
//   rst       in   1              synchronous active-high reset, clears rd_data
//   cap_en    in   1              capture enable (read accepted this edge)
//   rd_addr   in   ADDR_W         read address of this port
//   mem_flat  in   DEPTH*DATA_W   whole storage array, entry e at [e*DATA_W +: DATA_W]
//   wr_en     in   1              accepted write this edge (bypass build only)
//   wr_addr   in   ADDR_W         write address (bypass build only)
//   wr_data   in   DATA_W         write data (bypass build only)
//   rd_data   out  DATA_W         registered read data
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cap_en,
  input  logic [ADDR_W-1:0]              rd_addr,
  input  logic [(2**ADDR_W)*DATA_W-1:0]  mem_flat,
`ifdef REGFILE_BYPASS_EN
  input  logic                           wr_en,
  input  logic [ADDR_W-1:0]              wr_addr,
  input  logic [DATA_W-1:0]              wr_data,
`endif
  output logic [DATA_W-1:0]              rd_data
);

  logic [DATA_W-1:0] mem_word_s;
  logic [DATA_W-1:0] rd_next_s;
  logic [DATA_W-1:0] rd_data_r;

  assign mem_word_s = mem_flat[slice_lsb(32'(rd_addr), DATA_W) +: DATA_W];

  // Select the value this port captures: zero gate wins over the bypass.
  always_comb begin
    rd_next_s = mem_word_s;
    if ((ZERO_REG != 0) && (rd_addr == {ADDR_W{1'b0}})) begin
      rd_next_s = {DATA_W{1'b0}};
    end
`ifdef REGFILE_BYPASS_EN
    else if (wr_en && (wr_addr == rd_addr)) begin
      rd_next_s = wr_data;
    end
`endif
    else begin
      rd_next_s = mem_word_s;
    end
  end

  // Output register: holds its value whenever no read is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r <= {DATA_W{1'b0}};
    end else if (cap_en) begin
      rd_data_r <= rd_next_s;
    end else begin
      rd_data_r <= rd_data_r;
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/register_file_mp.sv
// register_file_mp
//   Parametrised multi-read-port integer register file with hard-wired zero
//   register, registered reads with valid flag and a hardware clear sequence
//   (one entry per cycle, DEPTH cycles) after every reset.
//   Optional feature: define REGFILE_BYPASS_EN for write-first forwarding of a
//   same-edge write to any read port reading the same address; without it,
//   reads are read-before-write and no comparator exists.
// Ports
//   i_Clk          in   1              clock, rising edge
//   i_Rst          in   1              synchronous active-high reset
//   i_Enb          in   1              read enable shared by all read ports
//   iW_Enb         in   1              write enable
//   iv_Read_R      in   N_RD*ADDR_W    read addresses, port k at [k*ADDR_W +: ADDR_W]
//   iv_Write_R     in   ADDR_W         write address
//   iv_Write_Data  in   DATA_W         write data
//   ov_Data_R      out  N_RD*DATA_W    read data, port k at [k*DATA_W +: DATA_W]
//   o_Valid        out  1              ov_Data_R holds the result of an accepted read
//   o_Busy         out  1              clear sequence in progress
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int N_RD     = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst,
  input  logic                     i_Enb,
  input  logic                     iW_Enb,
  input  logic [N_RD*ADDR_W-1:0]   iv_Read_R,
  input  logic [ADDR_W-1:0]        iv_Write_R,
  input  logic [DATA_W-1:0]        iv_Write_Data,
  output logic [N_RD*DATA_W-1:0]   ov_Data_R,
  output logic                     o_Valid,
  output logic                     o_Busy
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

  state_t                    state_r;
  logic [ADDR_W-1:0]         cnt_r;
  logic                      busy_r;
  logic                      valid_r;
  logic [DEPTH*DATA_W-1:0]   mem_r;

  logic                      clear_we_s;
  logic                      wr_fire_s;
  logic                      rd_fire_s;
  logic                      wr_zero_s;

  assign clear_we_s = (state_r == ST_CLEAR);
  assign rd_fire_s  = (state_r == ST_READY) && i_Enb;
  // Writes to entry 0 are dropped when it is the hard-wired zero register.
  assign wr_zero_s  = (ZERO_REG != 0) && (iv_Write_R == {ADDR_W{1'b0}});
  assign wr_fire_s  = (state_r == ST_READY) && iW_Enb && !wr_zero_s;

  // Controller FSM: clear counter, state and the registered status flags.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_r <= ST_CLEAR;
      cnt_r   <= {ADDR_W{1'b0}};
      busy_r  <= 1'b1;
      valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          valid_r <= 1'b0;
          cnt_r   <= cnt_r + ADDR_W'(1);
          if (cnt_r == CNT_LAST) begin
            state_r <= ST_READY;
            busy_r  <= 1'b0;
          end else begin
            state_r <= ST_CLEAR;
            busy_r  <= 1'b1;
          end
        end
        ST_READY: begin
          state_r <= ST_READY;
          busy_r  <= 1'b0;
          valid_r <= i_Enb;
        end
        default: begin
          state_r <= ST_CLEAR;
          cnt_r   <= {ADDR_W{1'b0}};
          busy_r  <= 1'b1;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Storage write port: clear sequence zeroes one entry per cycle, otherwise
  // accepted writes update the addressed entry. Storage itself has no reset.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      if (clear_we_s) begin
        mem_r[slice_lsb(32'(cnt_r), DATA_W) +: DATA_W] <= {DATA_W{1'b0}};
      end else if (wr_fire_s) begin
        mem_r[slice_lsb(32'(iv_Write_R), DATA_W) +: DATA_W] <= iv_Write_Data;
      end
    end
  end

  for (genvar k = 0; k < N_RD; k++) begin : g_rd
    regfile_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_port (
      .clk      (i_Clk),
      .rst      (i_Rst),
      .cap_en   (rd_fire_s),
      .rd_addr  (iv_Read_R[k*ADDR_W +: ADDR_W]),
      .mem_flat (mem_r),
`ifdef REGFILE_BYPASS_EN
      .wr_en    (wr_fire_s),
      .wr_addr  (iv_Write_R),
      .wr_data  (iv_Write_Data),
`endif
      .rd_data  (ov_Data_R[slice_lsb(k, DATA_W) +: DATA_W])
    );
  end

  assign o_Valid = valid_r;
  assign o_Busy  = busy_r;

endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp
//   Directed scenarios plus randomized traffic for register_file_mp (N_RD=3),
//   compared every cycle against a behavioural model of the register file.
module tb_register_file_mp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int N_RD   = 3;
  localparam int DEPTH  = 32;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                   i_Clk = 1'b0;
  logic                   i_Rst = 1'b1;
  logic                   i_Enb = 1'b0;
  logic                   iW_Enb = 1'b0;
  logic [N_RD*ADDR_W-1:0] iv_Read_R = '0;
  logic [ADDR_W-1:0]      iv_Write_R = '0;
  logic [DATA_W-1:0]      iv_Write_Data = '0;
  logic [N_RD*DATA_W-1:0] ov_Data_R;
  logic                   o_Valid;
  logic                   o_Busy;

  register_file_mp #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_RD(N_RD), .ZERO_REG(1)
  ) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Enb(i_Enb), .iW_Enb(iW_Enb),
    .iv_Read_R(iv_Read_R), .iv_Write_R(iv_Write_R), .iv_Write_Data(iv_Write_Data),
    .ov_Data_R(ov_Data_R), .o_Valid(o_Valid), .o_Busy(o_Busy)
  );

  always #5 i_Clk = ~i_Clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_data [N_RD];
  logic        m_valid;
  logic        m_busy;
  int          m_clear_left;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] port_out(input int k);
    logic [N_RD*DATA_W-1:0] v;
    v = ov_Data_R;
    return v[k*DATA_W +: DATA_W];
  endfunction

  // One clock edge with the given inputs; model advances, then all outputs are compared.
  task automatic cycle(input logic rst, input logic en, input logic wen,
                       input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] wa, input logic [31:0] wd);
    logic [4:0] ra [N_RD];
    ra[0] = a0; ra[1] = a1; ra[2] = a2;
    i_Rst = rst; i_Enb = en; iW_Enb = wen;
    iv_Read_R = {a2, a1, a0}; iv_Write_R = wa; iv_Write_Data = wd;
    @(posedge i_Clk);
    if (rst) begin
      m_clear_left = DEPTH;
      m_busy = 1'b1;
      m_valid = 1'b0;
      for (int k = 0; k < N_RD; k++) m_data[k] = 32'h0;
    end else if (m_clear_left > 0) begin
      m_clear_left--;
      m_valid = 1'b0;
      if (m_clear_left == 0) begin
        for (int e = 0; e < DEPTH; e++) m_mem[e] = 32'h0;
        m_busy = 1'b0;
      end
    end else begin
      m_valid = en;
      if (en) begin
        for (int k = 0; k < N_RD; k++) begin
          if (ra[k] == 5'd0)                  m_data[k] = 32'h0;
          else if (BYP && wen && ra[k] == wa) m_data[k] = wd;
          else                                m_data[k] = m_mem[ra[k]];
        end
      end
      if (wen && wa != 5'd0) m_mem[wa] = wd;
    end
    #1;
    check("busy", {31'b0, o_Busy}, {31'b0, m_busy});
    check("valid", {31'b0, o_Valid}, {31'b0, m_valid});
    for (int k = 0; k < N_RD; k++) check($sformatf("rd%0d", k), port_out(k), m_data[k]);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0);
  endtask

  initial begin
    int bc;
    logic [4:0] a0, a1, a2, wa;

    // 1. reset pulse, busy length, every entry reads zero
    cycle(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0);
    check("rst_busy", {31'b0, o_Busy}, 32'd1);
    check("rst_valid", {31'b0, o_Valid}, 32'd0);
    bc = 1;
    for (int i = 0; i < 40 && o_Busy; i++) begin
      idle();
      if (o_Busy) bc++;
    end
    check("busy_len", bc, 32'd32);
    for (int a = 0; a < DEPTH; a++) begin
      cycle(1'b0, 1'b1, 1'b0, 5'(a), 5'(a), 5'(31 - a), 5'd0, 32'h0);
      check("clr_rd", port_out(0), 32'h0);
    end

    // 2. basic write then dual read
    cycle(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 5'd5, 32'hDEADBEEF);
    cycle(1'b0, 1'b1, 1'b0, 5'd5, 5'd5, 5'd0, 5'd0, 32'h0);
    check("x5_p0", port_out(0), 32'hDEADBEEF);
    check("x5_p1", port_out(1), 32'hDEADBEEF);
    check("x5_valid", {31'b0, o_Valid}, 32'd1);

    // 3. zero register ignores writes
    cycle(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 32'h12345678);
    cycle(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0);
    check("x0", port_out(0), 32'h0);

    // 4. same-edge write and read
    cycle(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 5'd7, 32'h1);
    cycle(1'b0, 1'b1, 1'b1, 5'd7, 5'd7, 5'd7, 5'd7, 32'h2);
    check("x7_same", port_out(0), BYP ? 32'h2 : 32'h1);
    cycle(1'b0, 1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 5'd0, 32'h0);
    check("x7_after", port_out(0), 32'h2);

    // 6. read enable low: data holds, valid drops; N_RD=3 distinct addresses
    cycle(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 5'd1, 32'h11111111);
    cycle(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 5'd2, 32'h22222222);
    cycle(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 5'd3, 32'h33333333);
    cycle(1'b0, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 5'd0, 32'h0);
    check("p0_x1", port_out(0), 32'h11111111);
    check("p1_x2", port_out(1), 32'h22222222);
    check("p2_x3", port_out(2), 32'h33333333);
    cycle(1'b0, 1'b0, 1'b0, 5'd5, 5'd7, 5'd9, 5'd0, 32'h0);
    check("hold_p2", port_out(2), 32'h33333333);
    check("hold_valid", {31'b0, o_Valid}, 32'd0);

    // 5. reset during clear, write during clear dropped
    cycle(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0);
    for (int i = 0; i < 9; i++) idle();
    cycle(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0);
    bc = 1;
    cycle(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 5'd3, 32'hA5);
    if (o_Busy) bc++;
    for (int i = 0; i < 40 && o_Busy; i++) begin
      idle();
      if (o_Busy) bc++;
    end
    check("busy_len2", bc, 32'd32);
    cycle(1'b0, 1'b1, 1'b0, 5'd3, 5'd3, 5'd3, 5'd0, 32'h0);
    check("x3_dropped", port_out(0), 32'h0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      a0 = 5'($urandom_range(31)); a1 = 5'($urandom_range(31)); a2 = 5'($urandom_range(31));
      wa = ($urandom_range(3) == 0) ? a0 : 5'($urandom_range(31));
      cycle(($urandom_range(299) == 0), 1'($urandom), 1'($urandom), a0, a1, a2, wa, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
